// File: rtl/wb_pkg.sv
// Shared types and constants for the MIPS writeback stage.
package wb_pkg;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned LDTYPE_W = 3;

  typedef enum logic [LDTYPE_W-1:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4
  } ldtype_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOAD,
    COMMIT
  } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB handshake, data-memory response and regfile/bypass/hazard outputs.
interface wb_stage_if
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) ();

  logic                  IN_VALID;
  logic                  IN_READY;
  logic                  IN_REGWRITE;
  logic [ADDR_WIDTH-1:0] IN_DEST;
  logic [DATA_WIDTH-1:0] IN_RESULT;
  logic                  IN_IS_LOAD;
  logic [LDTYPE_W-1:0]   IN_LDTYPE;
  logic [1:0]            IN_ADDR_LO;
  logic                  DMEM_RVALID;
  logic [DATA_WIDTH-1:0] DMEM_RDATA;
  logic                  WB_WE3;
  logic [ADDR_WIDTH-1:0] WB_A3;
  logic [DATA_WIDTH-1:0] WB_WD3;
  logic                  PEND_VALID;
  logic [ADDR_WIDTH-1:0] PEND_A;
  logic [CNT_WIDTH-1:0]  RETIRED_CNT;
  logic                  ERR_SPURIOUS;

  modport master (
    output IN_VALID, IN_REGWRITE, IN_DEST, IN_RESULT, IN_IS_LOAD, IN_LDTYPE,
           IN_ADDR_LO, DMEM_RVALID, DMEM_RDATA,
    input  IN_READY, WB_WE3, WB_A3, WB_WD3, PEND_VALID, PEND_A, RETIRED_CNT,
           ERR_SPURIOUS
  );

  modport slave (
    input  IN_VALID, IN_REGWRITE, IN_DEST, IN_RESULT, IN_IS_LOAD, IN_LDTYPE,
           IN_ADDR_LO, DMEM_RVALID, DMEM_RDATA,
    output IN_READY, WB_WE3, WB_A3, WB_WD3, PEND_VALID, PEND_A, RETIRED_CNT,
           ERR_SPURIOUS
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// Little-endian byte/halfword lane select with sign or zero extension.
module load_align
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [LDTYPE_W-1:0]   ldtype,
  input  logic [1:0]            addr_lo,
  output logic [DATA_WIDTH-1:0] aligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = rdata[{addr_lo, 3'b000} +: 8];
    half_v  = rdata[{addr_lo[1], 4'b0000} +: 16];
    aligned = rdata;
    // Encodings above LW fall through to the full word.
    case (ldtype)
      LB:      aligned = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      LBU:     aligned = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      LH:      aligned = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      LHU:     aligned = {{(DATA_WIDTH-16){1'b0}}, half_v};
      default: aligned = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one-slot holding register feeding the regfile write port,
// with load alignment, ID bypass, pending-load report and retire counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  wb_stage_if.slave   bus
);

  wb_state_e             state_q;
  logic                  regwrite_q;
  logic [ADDR_WIDTH-1:0] dest_q;
  logic [LDTYPE_W-1:0]   ldtype_q;
  logic [1:0]            addr_lo_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] a3_q;
  logic [DATA_WIDTH-1:0] wd3_q;
  logic                  pend_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  err_q;

  logic                  in_ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] aligned;

  assign in_ready = (state_q != WAIT_LOAD);
  assign accept   = bus.IN_VALID && in_ready;

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .rdata   (bus.DMEM_RDATA),
    .ldtype  (ldtype_q),
    .addr_lo (addr_lo_q),
    .aligned (aligned)
  );

  // Write enable and pending flag are computed on entry to COMMIT/WAIT_LOAD
  // so every output comes straight from a flop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      regwrite_q <= 1'b0;
      dest_q     <= '0;
      ldtype_q   <= '0;
      addr_lo_q  <= '0;
      we_q       <= 1'b0;
      a3_q       <= '0;
      wd3_q      <= '0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (state_q == COMMIT) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      case (state_q)
        WAIT_LOAD: begin
          if (bus.DMEM_RVALID) begin
            state_q <= COMMIT;
            pend_q  <= 1'b0;
            we_q    <= regwrite_q && (dest_q != ADDR_WIDTH'(REG_ZERO));
            a3_q    <= dest_q;
            wd3_q   <= aligned;
          end
        end
        default: begin
          if (bus.DMEM_RVALID) begin
            err_q <= 1'b1;
          end
          if (accept) begin
            regwrite_q <= bus.IN_REGWRITE;
            dest_q     <= bus.IN_DEST;
            ldtype_q   <= bus.IN_LDTYPE;
            addr_lo_q  <= bus.IN_ADDR_LO;
            if (bus.IN_IS_LOAD) begin
              state_q <= WAIT_LOAD;
              pend_q  <= bus.IN_REGWRITE && (bus.IN_DEST != ADDR_WIDTH'(REG_ZERO));
            end else begin
              state_q <= COMMIT;
              we_q    <= bus.IN_REGWRITE && (bus.IN_DEST != ADDR_WIDTH'(REG_ZERO));
              a3_q    <= bus.IN_DEST;
              wd3_q   <= bus.IN_RESULT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.IN_READY     = in_ready;
  assign bus.WB_WE3       = we_q;
  assign bus.WB_A3        = a3_q;
  assign bus.WB_WD3       = wd3_q;
  assign bus.PEND_VALID   = pend_q;
  assign bus.PEND_A       = dest_q;
  assign bus.RETIRED_CNT  = cnt_q;
  assign bus.ERR_SPURIOUS = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table plus directed reset/error/wrap sequences.
module tb_wb_stage;

  logic clk;
  logic rst_n;

  wb_stage_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(32)) bus ();
  wb_stage_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(4))  bus4 ();

  wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(32)) u_dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(4)) u_dut4 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus4)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        ld;
    logic [2:0]  lt;
    logic [1:0]  lo;
    logic [31:0] rdata;
    int unsigned gap;
    logic [31:0] exp_wd;
  } vec_t;

  localparam int unsigned NVEC = 14;
  vec_t vt[NVEC];

  logic [36:0] sb[$];
  int unsigned nchecks = 0;
  int unsigned nerr    = 0;
  int unsigned cnt_exp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every regfile write the DUT produces must match the oldest expected write.
  logic [36:0] sb_e;
  always @(negedge clk) begin
    if (bus.WB_WE3 === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(bus.WB_A3), 32'h0000_00ff);
      end else begin
        sb_e = sb.pop_front();
        check("sb_a3", 32'(bus.WB_A3), 32'(sb_e[36:32]));
        check("sb_wd3", bus.WB_WD3, sb_e[31:0]);
      end
    end
  end

  task automatic idle_inputs();
    bus.IN_VALID    = 1'b0;
    bus.IN_REGWRITE = 1'b0;
    bus.IN_DEST     = '0;
    bus.IN_RESULT   = '0;
    bus.IN_IS_LOAD  = 1'b0;
    bus.IN_LDTYPE   = '0;
    bus.IN_ADDR_LO  = '0;
    bus.DMEM_RVALID = 1'b0;
    bus.DMEM_RDATA  = '0;
  endtask

  task automatic send_alu(input logic [4:0] dest, input logic [31:0] res);
    logic we_exp;
    we_exp = (dest != 5'd0);
    check("ready_alu", 32'(bus.IN_READY), 32'd1);
    bus.IN_VALID    = 1'b1;
    bus.IN_REGWRITE = 1'b1;
    bus.IN_DEST     = dest;
    bus.IN_RESULT   = res;
    bus.IN_IS_LOAD  = 1'b0;
    if (we_exp) sb.push_back({dest, res});
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    check("we3_alu", 32'(bus.WB_WE3), 32'(we_exp));
    cnt_exp++;
  endtask

  task automatic run_vec(input vec_t v);
    logic we_exp;
    we_exp = v.rw && (v.dest != 5'd0);
    check("ready_accept", 32'(bus.IN_READY), 32'd1);
    bus.IN_VALID    = 1'b1;
    bus.IN_REGWRITE = v.rw;
    bus.IN_DEST     = v.dest;
    bus.IN_RESULT   = v.result;
    bus.IN_IS_LOAD  = v.ld;
    bus.IN_LDTYPE   = v.lt;
    bus.IN_ADDR_LO  = v.lo;
    if (!v.ld && we_exp) sb.push_back({v.dest, v.result});
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    if (v.ld) begin
      for (int unsigned c = 0; c < v.gap; c++) begin
        check("ready_wait", 32'(bus.IN_READY), 32'd0);
        check("pend_valid", 32'(bus.PEND_VALID), 32'(we_exp));
        check("pend_a", 32'(bus.PEND_A), 32'(v.dest));
        check("we3_wait", 32'(bus.WB_WE3), 32'd0);
        if (c == v.gap - 1) begin
          bus.DMEM_RVALID = 1'b1;
          bus.DMEM_RDATA  = v.rdata;
          if (we_exp) sb.push_back({v.dest, v.exp_wd});
        end
        @(negedge clk);
      end
      bus.DMEM_RVALID = 1'b0;
      check("pend_clear", 32'(bus.PEND_VALID), 32'd0);
    end
    check("we3", 32'(bus.WB_WE3), 32'(we_exp));
    if (we_exp) check("wd3", bus.WB_WD3, v.exp_wd);
    cnt_exp++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            rw    dest   result        ld    lt    lo     rdata         gap exp_wd
    vt[0]  = '{1'b1, 5'd5,  32'h11,       1'b0, 3'd0, 2'd0, 32'h0,        0, 32'h11};
    vt[1]  = '{1'b1, 5'd6,  32'h22,       1'b0, 3'd0, 2'd0, 32'h0,        0, 32'h22};
    vt[2]  = '{1'b1, 5'd0,  32'h33,       1'b0, 3'd0, 2'd0, 32'h0,        0, 32'h33};
    vt[3]  = '{1'b1, 5'd7,  32'h0,        1'b1, 3'd0, 2'd3, 32'h80FF_0102, 4, 32'hFFFF_FF80};
    vt[4]  = '{1'b1, 5'd8,  32'h0,        1'b1, 3'd3, 2'd2, 32'h8001_1234, 2, 32'h0000_8001};
    vt[5]  = '{1'b1, 5'd9,  32'h0,        1'b1, 3'd2, 2'd2, 32'h8001_1234, 1, 32'hFFFF_8001};
    vt[6]  = '{1'b1, 5'd10, 32'h0,        1'b1, 3'd1, 2'd2, 32'h80FF_0102, 1, 32'h0000_00FF};
    vt[7]  = '{1'b1, 5'd11, 32'h0,        1'b1, 3'd0, 2'd0, 32'h1234_567F, 3, 32'h0000_007F};
    vt[8]  = '{1'b1, 5'd12, 32'h0,        1'b1, 3'd2, 2'd3, 32'h8001_1234, 1, 32'hFFFF_8001};
    vt[9]  = '{1'b1, 5'd13, 32'h5555_5555, 1'b1, 3'd4, 2'd1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
    vt[10] = '{1'b1, 5'd14, 32'h0,        1'b1, 3'd6, 2'd3, 32'hCAFE_F00D, 2, 32'hCAFE_F00D};
    vt[11] = '{1'b1, 5'd15, 32'h0,        1'b1, 3'd3, 2'd0, 32'h8001_F234, 1, 32'h0000_F234};
    vt[12] = '{1'b1, 5'd0,  32'h0,        1'b1, 3'd4, 2'd0, 32'h1111_1111, 2, 32'h1111_1111};
    vt[13] = '{1'b0, 5'd3,  32'h77,       1'b0, 3'd0, 2'd0, 32'h0,        0, 32'h77};

    rst_n = 1'b0;
    idle_inputs();
    bus4.IN_VALID    = 1'b0;
    bus4.IN_REGWRITE = 1'b1;
    bus4.IN_DEST     = 5'd2;
    bus4.IN_RESULT   = '0;
    bus4.IN_IS_LOAD  = 1'b0;
    bus4.IN_LDTYPE   = '0;
    bus4.IN_ADDR_LO  = '0;
    bus4.DMEM_RVALID = 1'b0;
    bus4.DMEM_RDATA  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_we3", 32'(bus.WB_WE3), 32'd0);
    check("rst_wd3", bus.WB_WD3, 32'd0);
    check("rst_pend", 32'(bus.PEND_VALID), 32'd0);
    check("rst_cnt", bus.RETIRED_CNT, 32'd0);
    check("rst_err", 32'(bus.ERR_SPURIOUS), 32'd0);
    check("rst_ready", 32'(bus.IN_READY), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int unsigned i = 0; i < NVEC; i++) begin
      if (i == 3) begin
        @(negedge clk);
        check("cnt_after_3_alu", bus.RETIRED_CNT, 32'd3);
      end
      run_vec(vt[i]);
    end
    @(negedge clk);
    check("cnt_after_table", bus.RETIRED_CNT, 32'(cnt_exp));
    check("err_none_yet", 32'(bus.ERR_SPURIOUS), 32'd0);

    // Response with nothing outstanding.
    bus.DMEM_RVALID = 1'b1;
    bus.DMEM_RDATA  = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.DMEM_RVALID = 1'b0;
    check("spur_no_write", 32'(bus.WB_WE3), 32'd0);
    check("spur_err", 32'(bus.ERR_SPURIOUS), 32'd1);
    send_alu(5'd20, 32'h2020_2020);
    @(negedge clk);
    @(negedge clk);
    check("spur_sticky", 32'(bus.ERR_SPURIOUS), 32'd1);

    // Reset clears the sticky error, then build the counter up to 0x10.
    rst_n = 1'b0;
    #1;
    check("rst2_err", 32'(bus.ERR_SPURIOUS), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_exp = 0;
    for (int unsigned i = 0; i < 16; i++) send_alu(5'd1, 32'(i) + 32'h100);
    @(negedge clk);
    check("cnt_0x10", bus.RETIRED_CNT, 32'h10);

    // Load to $4 held in WAIT_LOAD when reset hits; the response is then late.
    check("ready_pre_ld", 32'(bus.IN_READY), 32'd1);
    bus.IN_VALID    = 1'b1;
    bus.IN_REGWRITE = 1'b1;
    bus.IN_DEST     = 5'd4;
    bus.IN_IS_LOAD  = 1'b1;
    bus.IN_LDTYPE   = 3'd4;
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    @(negedge clk);
    check("wait_pend", 32'(bus.PEND_VALID), 32'd1);
    check("wait_pend_a", 32'(bus.PEND_A), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we3", 32'(bus.WB_WE3), 32'd0);
    check("arst_a3", 32'(bus.WB_A3), 32'd0);
    check("arst_wd3", bus.WB_WD3, 32'd0);
    check("arst_pend", 32'(bus.PEND_VALID), 32'd0);
    check("arst_pend_a", 32'(bus.PEND_A), 32'd0);
    check("arst_cnt", bus.RETIRED_CNT, 32'd0);
    check("arst_ready", 32'(bus.IN_READY), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.IN_IS_LOAD  = 1'b0;
    bus.DMEM_RVALID = 1'b1;
    bus.DMEM_RDATA  = 32'h4444_4444;
    @(negedge clk);
    bus.DMEM_RVALID = 1'b0;
    check("late_rvalid_err", 32'(bus.ERR_SPURIOUS), 32'd1);
    check("late_rvalid_no_we", 32'(bus.WB_WE3), 32'd0);
    check("late_rvalid_cnt", bus.RETIRED_CNT, 32'd0);

    // Narrow counter instance: 15 commits reach all-ones, one more wraps to zero.
    for (int unsigned i = 0; i < 15; i++) begin
      bus4.IN_VALID  = 1'b1;
      bus4.IN_RESULT = 32'(i);
      @(negedge clk);
    end
    bus4.IN_VALID = 1'b0;
    @(negedge clk);
    check("cnt4_full", 32'(bus4.RETIRED_CNT), 32'd15);
    bus4.IN_VALID = 1'b1;
    @(negedge clk);
    bus4.IN_VALID = 1'b0;
    @(negedge clk);
    check("cnt4_wrap", 32'(bus4.RETIRED_CNT), 32'd0);

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the pipelined MIPS core, directly upstream of the 32x32 register file write port (A3/WD3/WE3).
- Accepts one retiring instruction per cycle from MEM over a valid/ready handshake.
- For loads, waits for the data-memory read response, then byte/halfword-aligns and extends it.
- Drives the single regfile write, publishes the same write as a forwarding bypass for ID, and reports a pending-load destination for the hazard unit.

Parameters:
- ADDR_WIDTH, 5, register index width.
- DATA_WIDTH, 32, datapath width.
- CNT_WIDTH, 32, retired-instruction counter width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  MEM presents an instruction.
- IN_READY  out  1  stage can accept this cycle.
- IN_REGWRITE  in  1  instruction writes a register.
- IN_DEST  in  ADDR_WIDTH  destination register index.
- IN_RESULT  in  DATA_WIDTH  ALU/link result; ignored for loads.
- IN_IS_LOAD  in  1  instruction is a load.
- IN_LDTYPE  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW; 5-7 treated as LW.
- IN_ADDR_LO  in  2  load effective address bits [1:0].
- DMEM_RVALID  in  1  load data valid, single-cycle pulse.
- DMEM_RDATA  in  DATA_WIDTH  raw little-endian word.
- WB_WE3  out  1  regfile write enable.
- WB_A3  out  ADDR_WIDTH  regfile write index.
- WB_WD3  out  DATA_WIDTH  regfile write data.
- PEND_VALID  out  1  a load is accepted but not yet written.
- PEND_A  out  ADDR_WIDTH  destination of that load.
- RETIRED_CNT  out  CNT_WIDTH  count of committed instructions.
- ERR_SPURIOUS  out  1  sticky; DMEM_RVALID seen outside WAIT_LOAD.

Behaviour:
- States:
  - IDLE: empty slot.
  - WAIT_LOAD: a load is held; waiting for data.
  - COMMIT: one cycle in which the write is driven.
- IN_READY = (state==IDLE) || (state==COMMIT). It is 0 throughout WAIT_LOAD.
- Accept = IN_VALID && IN_READY. On accept, latch REGWRITE, DEST, RESULT, IS_LOAD, LDTYPE, ADDR_LO.
- Transitions from IDLE or COMMIT:
  - accept of a non-load -> COMMIT.
  - accept of a load -> WAIT_LOAD.
  - no accept -> IDLE.
  - COMMIT with a non-load accept stays in COMMIT, giving a throughput of 1 instruction per cycle.
- WAIT_LOAD -> COMMIT on DMEM_RVALID. The aligned data replaces the latched result.
- Latency:
  - Non-load: WB_WE3 is asserted in the cycle after accept.
  - Load: WB_WE3 is asserted in the cycle after DMEM_RVALID.
  - A load never commits earlier than 2 cycles after accept.
- Write enable and bypass:
  - WB_WE3 = (state==COMMIT) && latched REGWRITE && (latched DEST != 0). Writes to $0 are suppressed but still counted.
  - WB_A3 and WB_WD3 are registered. They hold their last value outside COMMIT.
  - ID uses WB_WE3/WB_A3/WB_WD3 directly as its bypass, because the regfile only updates at the end of the cycle.
- Load alignment, byte lane n = bits [8n+7:8n]:
  - LB/LBU: lane = ADDR_LO.
  - LH/LHU: halfword = ADDR_LO[1]; ADDR_LO[0] is ignored.
  - LW: ADDR_LO is ignored.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- PEND_VALID = (state==WAIT_LOAD) && REGWRITE && DEST!=0. PEND_A = latched DEST.
- RETIRED_CNT increments by 1 on each COMMIT cycle and wraps modulo 2^CNT_WIDTH.
- ERR_SPURIOUS is set by DMEM_RVALID in IDLE or COMMIT (including the accept cycle of a load). It clears only on reset. A spurious response is otherwise ignored.
- Reset: async assert clears the state to IDLE. All outputs go to 0, RETIRED_CNT to 0 and ERR_SPURIOUS to 0.
  - A pending load is dropped.
  - A response arriving after reset sets ERR_SPURIOUS.

Decomposition:
- wb_pkg holds:
  - the ldtype_e enum (LB, LBU, LH, LHU, LW);
  - the wb_state_e enum (IDLE, WAIT_LOAD, COMMIT);
  - constants REG_ZERO = 0 and LDTYPE_W = 3.
- One combinational sub-module, load_align, with inputs (rdata, ldtype, addr_lo) and output (aligned data). It is instantiated once.

Test Plan:
- Back-to-back ALU ops to $5 = 0x11, $6 = 0x22, $0 = 0x33, on consecutive cycles -> WE3 pulses 1, 1, 0 on consecutive cycles; IN_READY stays 1; RETIRED_CNT = 3.
- LB with ADDR_LO = 3, RDATA = 0x80FF_0102, dest $7, RVALID 4 cycles after accept:
  - IN_READY = 0 and PEND_VALID = 1 with PEND_A = 7 for those cycles;
  - then WD3 = 0xFFFF_FF80.
- LHU with ADDR_LO = 2, RDATA = 0x8001_1234 -> WD3 = 0x0000_8001. LH at the same address -> WD3 = 0xFFFF_8001.
- RVALID pulsed in IDLE -> no write; ERR_SPURIOUS = 1 and it stays 1 until RST_N is asserted.
- RST_N asserted while in WAIT_LOAD, with RETIRED_CNT = 0x10 -> outputs and counter cleared immediately; IDLE; the late RVALID sets ERR_SPURIOUS.
- Start RETIRED_CNT at 0xFFFF_FFFF, commit one op -> RETIRED_CNT = 0.
